// File: rtl/execute_stage_pkg.sv
// Shared sizing, opcode and state encodings for the execute stage slice.
package execute_stage_pkg;

    localparam int DEF_WORD_SIZE     = 8;
    localparam int DEF_REG_ADDR_SIZE = 3;
    localparam int DEF_REG_NUM       = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_EXEC = 3'd2;
    localparam logic [2:0] ST_MUL  = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;

endpackage

// File: rtl/execute_stage_shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier; the start edge folds in multiplier bit 0,
// so the full product is stable in the cycle after busy drops.
module shift_add_multiplier #(
    parameter int WORD_SIZE = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [WORD_SIZE-1:0]     a,
    input  logic [WORD_SIZE-1:0]     b,
    output logic                     busy,
    output logic [2*WORD_SIZE-1:0]   product
);

    localparam int CW = $clog2(WORD_SIZE + 1);

    logic [2*WORD_SIZE-1:0] mcand;
    logic [WORD_SIZE-1:0]   mplier;
    logic [CW-1:0]          count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            product <= b[0] ? {{WORD_SIZE{1'b0}}, a} : '0;
            mcand   <= {{WORD_SIZE{1'b0}}, a} << 1;
            mplier  <= b >> 1;
            count   <= CW'(WORD_SIZE - 1);
        end else if (busy) begin
            if (mplier[0])
                product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - 1'b1;
            if (count == CW'(1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Multi-cycle execute stage: reads two operands from the register file, runs an ALU op
// or iterative multiply, and writes the result back through the set port.
import execute_stage_pkg::*;

module execute_stage #(
    parameter int WORD_SIZE     = DEF_WORD_SIZE,
    parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [2:0]               opcode,
    input  logic [REG_ADDR_SIZE-1:0] rd,
    input  logic [REG_ADDR_SIZE-1:0] rs1,
    input  logic [REG_ADDR_SIZE-1:0] rs2,
    output logic [REG_ADDR_SIZE-1:0] reg_num1,
    output logic [REG_ADDR_SIZE-1:0] reg_num2,
    output logic                     reg_get_enable,
    input  logic [WORD_SIZE-1:0]     reg_out1,
    input  logic [WORD_SIZE-1:0]     reg_out2,
    output logic [REG_ADDR_SIZE-1:0] reg_set_num,
    output logic [WORD_SIZE-1:0]     reg_set_val,
    output logic                     reg_set_enable,
    output logic [WORD_SIZE-1:0]     result,
    output logic                     flag_zero,
    output logic                     flag_carry,
    output logic                     done
);

    localparam logic [WORD_SIZE:0] SHIFT_LIMIT = (WORD_SIZE + 1)'(WORD_SIZE);

    logic [2:0]               state;
    logic [2:0]               op_q;
    logic [REG_ADDR_SIZE-1:0] rd_q;

    logic [WORD_SIZE:0]       sum;
    logic                     shift_oob;
    logic [WORD_SIZE-1:0]     alu_val;
    logic                     alu_carry;
    logic [WORD_SIZE-1:0]     wb_val;
    logic                     wb_carry;

    logic                     mul_start;
    logic                     mul_busy;
    logic [2*WORD_SIZE-1:0]   mul_product;

    assign mul_start = (state == ST_EXEC) && (op_q == OP_MUL);

    shift_add_multiplier #(.WORD_SIZE(WORD_SIZE)) u_mul (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (reg_out1),
        .b       (reg_out2),
        .busy    (mul_busy),
        .product (mul_product)
    );

    always_comb begin
        sum       = {1'b0, reg_out1} + {1'b0, reg_out2};
        shift_oob = {1'b0, reg_out2} >= SHIFT_LIMIT;
        alu_val   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_val   = sum[WORD_SIZE-1:0];
                alu_carry = sum[WORD_SIZE];
            end
            OP_SUB: begin
                alu_val   = reg_out1 - reg_out2;
                alu_carry = reg_out1 < reg_out2;
            end
            OP_AND:  alu_val = reg_out1 & reg_out2;
            OP_OR:   alu_val = reg_out1 | reg_out2;
            OP_XOR:  alu_val = reg_out1 ^ reg_out2;
            OP_SHL:  alu_val = shift_oob ? '0 : reg_out1 << reg_out2;
            OP_SHR:  alu_val = shift_oob ? '0 : reg_out1 >> reg_out2;
            default: alu_val = '0;
        endcase
    end

    // EXEC writes back ALU results directly; only the MUL state hands over the product.
    always_comb begin
        wb_val   = (state == ST_EXEC) ? alu_val   : mul_product[WORD_SIZE-1:0];
        wb_carry = (state == ST_EXEC) ? alu_carry : |mul_product[2*WORD_SIZE-1:WORD_SIZE];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            op_q           <= '0;
            rd_q           <= '0;
            instr_ready    <= 1'b1;
            reg_num1       <= '0;
            reg_num2       <= '0;
            reg_get_enable <= 1'b0;
            reg_set_num    <= '0;
            reg_set_val    <= '0;
            reg_set_enable <= 1'b0;
            result         <= '0;
            flag_zero      <= 1'b0;
            flag_carry     <= 1'b0;
            done           <= 1'b0;
        end else begin
            reg_get_enable <= 1'b0;
            reg_set_enable <= 1'b0;
            done           <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        op_q           <= opcode;
                        rd_q           <= rd;
                        reg_num1       <= rs1;
                        reg_num2       <= rs2;
                        reg_get_enable <= 1'b1;
                        instr_ready    <= 1'b0;
                        state          <= ST_READ;
                    end
                end
                ST_READ: state <= ST_EXEC;
                ST_EXEC, ST_MUL: begin
                    if (state == ST_EXEC && op_q == OP_MUL) begin
                        state <= ST_MUL;
                    end else if (state == ST_EXEC || !mul_busy) begin
                        reg_set_enable <= 1'b1;
                        reg_set_num    <= rd_q;
                        reg_set_val    <= wb_val;
                        result         <= wb_val;
                        flag_zero      <= (wb_val == '0);
                        flag_carry     <= wb_carry;
                        done           <= 1'b1;
                        state          <= ST_WB;
                    end
                end
                ST_WB: begin
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: behavioural register file, directed scenarios and a random
// instruction stream checked against an arithmetic reference model.
module tb_execute_stage;

    localparam int W   = 8;
    localparam int A   = 3;
    localparam int MOD = 256;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [2:0]   opcode = '0;
    logic [A-1:0] rd = '0, rs1 = '0, rs2 = '0;
    logic [A-1:0] reg_num1, reg_num2, reg_set_num;
    logic         reg_get_enable, reg_set_enable;
    logic [W-1:0] reg_out1, reg_out2, reg_set_val, result;
    logic         flag_zero, flag_carry, done;

    logic         pre_en = 1'b0;
    logic [A-1:0] pre_num = '0;
    logic [W-1:0] pre_val = '0;
    logic [W-1:0] rf [8];

    int n_checks = 0;
    int n_fail   = 0;
    int model_regs [8];

    always #5 clock = ~clock;

    execute_stage #(.WORD_SIZE(W), .REG_ADDR_SIZE(A)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .opcode         (opcode),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .reg_num1       (reg_num1),
        .reg_num2       (reg_num2),
        .reg_get_enable (reg_get_enable),
        .reg_out1       (reg_out1),
        .reg_out2       (reg_out2),
        .reg_set_num    (reg_set_num),
        .reg_set_val    (reg_set_val),
        .reg_set_enable (reg_set_enable),
        .result         (result),
        .flag_zero      (flag_zero),
        .flag_carry     (flag_carry),
        .done           (done)
    );

    // Register file with a registered read port and a bench-owned preload mux on the set port.
    always @(posedge clock) begin
        if (reg_get_enable) begin
            reg_out1 <= rf[reg_num1];
            reg_out2 <= rf[reg_num2];
        end
        if (pre_en)
            rf[pre_num] <= pre_val;
        else if (reg_set_enable)
            rf[reg_set_num] <= reg_set_val;
    end

    initial begin
        reg_out1 = '0;
        reg_out2 = '0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic void ref_exec(input int op, input int x, input int y,
                                     output int val, output int carry);
        int p;
        carry = 0;
        case (op)
            0: begin p = x + y; val = p % MOD; carry = (p >= MOD) ? 1 : 0; end
            1: begin val = (x - y + MOD) % MOD; carry = (x < y) ? 1 : 0; end
            2: val = x & y;
            3: val = x | y;
            4: val = x ^ y;
            5: val = (y >= W) ? 0 : (x * (1 << y)) % MOD;
            6: val = (y >= W) ? 0 : x / (1 << y);
            default: begin p = x * y; val = p % MOD; carry = (p >= MOD) ? 1 : 0; end
        endcase
    endfunction

    task automatic preload(input int idx, input int val);
        @(negedge clock);
        pre_en  = 1'b1;
        pre_num = A'(idx);
        pre_val = W'(val);
        @(negedge clock);
        pre_en  = 1'b0;
        model_regs[idx] = val;
    endtask

    // Called at a negedge in IDLE; returns just after the accepting edge.
    task automatic start(input int op, input int d, input int s1, input int s2, input bit hold);
        opcode      = 3'(op);
        rd          = A'(d);
        rs1         = A'(s1);
        rs2         = A'(s2);
        instr_valid = 1'b1;
        check_eq("ready_before_accept", instr_ready, 1);
        @(posedge clock);
        #1;
        if (!hold)
            instr_valid = 1'b0;
    endtask

    // Waits for done, checks latency, writeback port, flags, and the register file afterwards.
    task automatic wait_done(input string tag, input int d, input int exp_val, input int exp_carry,
                             input int exp_lat);
        int k;
        bit both;
        k = 1;
        both = 1'b0;
        @(negedge clock);
        while (!done && k < 40) begin
            if (instr_ready) both = 1'b1;
            if (reg_get_enable && reg_set_enable) both = 1'b1;
            @(negedge clock);
            k++;
        end
        check_eq({tag, "_done_seen"}, done, 1);
        check_eq({tag, "_latency"}, k, exp_lat);
        check_eq({tag, "_busy_window_ok"}, both, 0);
        check_eq({tag, "_set_enable"}, reg_set_enable, 1);
        check_eq({tag, "_set_num"}, reg_set_num, d);
        check_eq({tag, "_set_val"}, reg_set_val, exp_val);
        check_eq({tag, "_result"}, result, exp_val);
        check_eq({tag, "_flag_zero"}, flag_zero, (exp_val == 0) ? 1 : 0);
        check_eq({tag, "_flag_carry"}, flag_carry, exp_carry);
        @(negedge clock);
        check_eq({tag, "_rf_written"}, rf[d], exp_val);
        check_eq({tag, "_ready_after"}, instr_ready, 1);
        check_eq({tag, "_done_pulse"}, done, 0);
        model_regs[d] = exp_val;
    endtask

    task automatic run_op(input string tag, input int op, input int d, input int s1, input int s2);
        int v, c;
        ref_exec(op, model_regs[s1], model_regs[s2], v, c);
        start(op, d, s1, s2, 1'b0);
        wait_done(tag, d, v, c, (op == 7) ? 11 : 3);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int v, c;
        bit seen_set;
        repeat (3) @(negedge clock);
        check_eq("reset_instr_ready", instr_ready, 1);
        check_eq("reset_get_enable", reg_get_enable, 0);
        check_eq("reset_set_enable", reg_set_enable, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_flags", {flag_zero, flag_carry}, 0);
        check_eq("reset_result", result, 0);
        check_eq("reset_set_val", reg_set_val, 0);
        check_eq("reset_indices", {reg_num1, reg_num2, reg_set_num}, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) preload(i, 0);

        preload(1, 200); preload(2, 100);
        @(negedge clock);
        run_op("add_carry", 0, 3, 1, 2);

        preload(1, 57);
        @(negedge clock);
        run_op("sub_self", 1, 4, 1, 1);

        preload(1, 8'h81); preload(2, 1);
        @(negedge clock);
        run_op("shl_1", 5, 5, 1, 2);

        preload(2, 9);
        @(negedge clock);
        run_op("shl_oob", 5, 5, 1, 2);

        // MUL with instr_valid held high and the inputs changed to another instruction.
        preload(1, 20); preload(2, 15);
        @(negedge clock);
        ref_exec(7, 20, 15, v, c);
        start(7, 6, 1, 2, 1'b1);
        opcode = 3'd0; rd = 3'd7; rs1 = 3'd1; rs2 = 3'd2;
        wait_done("mul_held", 6, v, c, 11);
        ref_exec(0, model_regs[1], model_regs[2], v, c);
        start(0, 7, 1, 2, 1'b0);
        wait_done("add_after_mul", 7, v, c, 3);

        // Reset in the fourth MUL cycle drops the instruction.
        preload(6, 8'h55);
        @(negedge clock);
        start(7, 6, 1, 2, 1'b0);
        seen_set = 1'b0;
        for (int k = 1; k < 6; k++) begin
            @(negedge clock);
            if (reg_set_enable) seen_set = 1'b1;
        end
        reset_n = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (reg_set_enable) seen_set = 1'b1;
        end
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("rst_ready_after_release", instr_ready, 1);
        check_eq("rst_result_cleared", result, 0);
        repeat (14) begin
            @(negedge clock);
            if (reg_set_enable || done) seen_set = 1'b1;
        end
        check_eq("rst_no_write", seen_set, 0);
        check_eq("rst_r6_kept", rf[6], 8'h55);

        preload(1, 3);
        @(negedge clock);
        run_op("b2b_rd_eq_rs1_a", 0, 1, 1, 1);
        run_op("b2b_rd_eq_rs1_b", 0, 1, 1, 1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0)
                preload($urandom_range(0, 7), $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0)
                preload($urandom_range(0, 7), $urandom_range(0, 10));
            @(negedge clock);
            run_op($sformatf("rand%0d", n), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 7));
        end

        for (int i = 0; i < 8; i++)
            check_eq($sformatf("final_r%0d", i), rf[i], model_regs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

- Single-issue, multi-cycle execute stage that sits directly upstream of the register file.
- Per accepted instruction it:
  - issues the two-operand read on the register file's get port;
  - computes an ALU or iterative-multiply result;
  - writes the result back through the register file's set port.
- It is the sole driver of the register file's address, enable and write-data inputs.
- Instruction fetch/decode feeds it through a valid/ready handshake.

## Interface

Parameters (from `parameters.vh`):
- `WORD_SIZE`, from parameters.vh: operand/result width.
- `REG_ADDR_SIZE`, from parameters.vh: register index width.
- `REG_NUM`, from parameters.vh: number of registers. Not used for logic.

Ports:
- `clock` in 1: single clock, all logic on posedge.
- `reset_n` in 1: synchronous, active-low reset.
- `instr_valid` in 1: decode presents an instruction.
- `instr_ready` out 1: stage can accept an instruction.
- `opcode` in 3: operation, encodings in package.
- `rd`, `rs1`, `rs2` in REG_ADDR_SIZE: destination and source register indices.
- `reg_num1`, `reg_num2` out REG_ADDR_SIZE: to register file `num1`/`num2`.
- `reg_get_enable` out 1: to register file `get_enable`.
- `reg_out1`, `reg_out2` in WORD_SIZE: from register file `out1`/`out2`.
- `reg_set_num` out REG_ADDR_SIZE: to register file `set_num`.
- `reg_set_val` out WORD_SIZE: to register file `set_val`.
- `reg_set_enable` out 1: to register file `set_enable`.
- `result` out WORD_SIZE: last written-back value, held until next writeback.
- `flag_zero` out 1: set when `result == 0`.
- `flag_carry` out 1: carry, borrow or overflow of last operation.
- `done` out 1: one-cycle pulse coincident with writeback.

## Operation

Opcodes:
- ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, MUL=7.

State machine:
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid && instr_ready`, latch `opcode`, `rd`, `rs1`, `rs2` → READ.
- READ:
  - `reg_get_enable`=1, `reg_num1`=rs1, `reg_num2`=rs2 → EXEC.
- EXEC:
  - `reg_out1`/`reg_out2` are valid this cycle; capture them as operands.
  - Non-MUL: compute into the result register → WB.
  - MUL: load multiplier → MUL.
- MUL:
  - Shift-add, one multiplier bit per cycle, WORD_SIZE cycles → WB.
- WB:
  - `reg_set_enable`=1, `reg_set_num`=rd, `reg_set_val`=result.
  - Update `result` and the flags; `done`=1 → IDLE.

Arithmetic:
- All operations are unsigned; results are truncated to WORD_SIZE.
- ADD: `flag_carry` = bit WORD_SIZE of the (WORD_SIZE+1)-bit sum.
- SUB: `flag_carry` = 1 iff op1 < op2 (borrow).
- SHL/SHR:
  - Shift amount = op2, logical.
  - Amount ≥ WORD_SIZE gives 0.
  - `flag_carry` = 0.
- AND/OR/XOR: `flag_carry` = 0.
- MUL:
  - Full 2·WORD_SIZE product is formed; the low half is written back.
  - `flag_carry` = 1 iff the high half ≠ 0.

Boundary conditions:
- `rd` may equal `rs1` or `rs2`. Operands are captured in EXEC, so the write in WB is safe.
- `instr_valid` outside IDLE is ignored. Inputs are not sampled.
- Reset in any state:
  - Next state is IDLE.
  - No write is issued in that cycle or after.
  - The in-flight instruction is dropped.
- Register file `reset_enable` is owned by the top level, not this block.

## Timing

Reset values:
- `instr_ready`=1.
- All enables, `done` and flags = 0.
- `result`, `reg_set_val` and all index outputs = 0.

Latency (E0 = accepting edge):
- READ in the cycle after E0.
- EXEC the cycle after.
- Non-MUL: WB the cycle after that. Register write lands at the end of the WB cycle, i.e. 3 cycles after E0.
- MUL: WB 3+WORD_SIZE cycles after E0.

Throughput and handshake:
- Next acceptance is possible on the edge ending the first IDLE cycle after WB.
- Throughput: 1 instruction per 4 cycles (non-MUL).
- `instr_ready` is low in READ, EXEC, MUL and WB.

Output timing:
- All outputs are registered.
- `reg_get_enable` and `reg_set_enable` are never high in the same cycle.

## Structure

- Shared package/header (`parameters.vh` extension):
  - opcode localparams.
  - state encodings (IDLE, READ, EXEC, MUL, WB).
- Sub-module `shift_add_multiplier`:
  - inputs: start, a, b.
  - outputs: busy, product[2·WORD_SIZE-1:0].
  - WORD_SIZE-cycle iterative.
  - Uses the same `clock`/`reset_n`.
- ALU ops are inline combinational in EXEC.

## Test plan

All scenarios use WORD_SIZE=8 with the bench wiring the real register file. Preload via a bench-owned set-port mux.
- ADD r3←r1+r2, r1=200, r2=100:
  - r3=44, `flag_carry`=1, `flag_zero`=0.
  - `done` 3 cycles after accept.
- SUB r4←r1−r1, r1=57:
  - r4=0, `flag_zero`=1, `flag_carry`=0.
- SHL r5←r1<<r2, r1=0x81, r2=1 → r5=0x02.
- SHL r5←r1<<r2, r2=9 → r5=0.
- MUL r6←r1·r2, r1=20, r2=15:
  - r6=44 (300 mod 256), `flag_carry`=1.
  - `done` exactly 11 cycles after accept.
  - `instr_valid` held high throughout; the second instruction is accepted only after `done`.
- Reset mid-operation:
  - Drive `reset_n`=0 during MUL cycle 4, r6 preloaded 0x55.
  - `reg_set_enable` never asserts, r6 stays 0x55.
  - `instr_ready`=1 in the cycle after reset releases.
- Back-to-back, `rd`=`rs1` (r1←r1+r1, r1=3):
  - r1=6, then a second issue gives r1=12.
